// File: rtl/maria_lineram_dbuf_if.sv
// rtl/maria_lineram_dbuf_if.sv - pixel byte handshake between writer and line RAM engine
interface maria_lineram_dbuf_if;
    logic [7:0] PIX_DATA;
    logic       PIX_VALID;
    logic       PIX_READY;

    modport master (output PIX_DATA, output PIX_VALID, input PIX_READY);
    modport slave  (input PIX_DATA, input PIX_VALID, output PIX_READY);
endinterface

// File: rtl/maria_lineram_dbuf.sv
// rtl/maria_lineram_dbuf.sv - double-buffered MARIA line RAM with sequential write/clear engine
module maria_lineram_dbuf #(
    parameter int CELLS  = 160,
    parameter int ADDR_W = 8,
    parameter int COL_W  = 9
) (
    input  logic                SYSCLK,
    input  logic                RESET,
    maria_lineram_dbuf_if.slave pix,
    input  logic [ADDR_W-1:0]   INPUT_ADDR,
    input  logic                INPUT_W,
    input  logic [2:0]          PALETTE,
    input  logic                PALETTE_W,
    input  logic                WM,
    input  logic                WM_W,
    input  logic [1:0]          READ_MODE,
    input  logic                KANGAROO_MODE,
    input  logic                BORDER_CONTROL,
    input  logic                COLOR_KILL,
    input  logic [7:0]          COLOR_MAP [25],
    input  logic                LRAM_SWAP,
    input  logic [COL_W-1:0]    LRAM_OUT_COL,
    output logic [7:0]          PLAYBACK,
    output logic                BUSY
);
    typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_WRITE, S_CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W:0]   CELLS_X   = (ADDR_W + 1)'(CELLS);
    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(2 * CELLS);

    logic [4:0] bank0 [CELLS];
    logic [4:0] bank1 [CELLS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, bptr_q, bptr_d, clr_q, clr_d;
    logic [2:0]        pal_q, pal_d, bpal_q, bpal_d;
    logic              wm_q, wm_d, bwm_q, bwm_d;
    logic [1:0]        rm_in_q, rm_in_d, rm_out_q, rm_out_d, k_q, k_d;
    logic              bank_q, bank_d, pend_q, pend_d;
    logic [7:0]        byte_q, byte_d, playback_q, playback_d;

    logic              wr_b0, wr_b1, do_swap;
    logic [ADDR_W-1:0] wr_idx, wr_cell_idx;
    logic [4:0]        wr_data, wr_cell;
    logic [7:0]        sh;
    logic              skip;

    // Cell k of the latched byte: shifting by 2k brings its transparency field to [7:6]
    always_comb begin
        sh          = byte_q << {k_q, 1'b0};
        wr_cell     = bwm_q ? {bpal_q[2], sh[3:2], sh[7:6]} : {bpal_q, sh[7:6]};
        wr_cell_idx = bptr_q + ADDR_W'(k_q);
        skip        = ({1'b0, wr_cell_idx} >= CELLS_X) || ((sh[7:6] == 2'b00) && !KANGAROO_MODE);
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        bptr_d   = bptr_q;
        clr_d    = clr_q;
        pal_d    = pal_q;
        bpal_d   = bpal_q;
        wm_d     = wm_q;
        bwm_d    = bwm_q;
        rm_in_d  = rm_in_q;
        rm_out_d = rm_out_q;
        k_d      = k_q;
        bank_d   = bank_q;
        pend_d   = pend_q | LRAM_SWAP;
        byte_d   = byte_q;
        wr_b0    = 1'b0;
        wr_b1    = 1'b0;
        wr_idx   = clr_q;
        wr_data  = 5'd0;
        do_swap  = 1'b0;
        if (PALETTE_W) pal_d = PALETTE;
        if (WM_W)      wm_d  = WM;
        case (state_q)
            S_CLEAR_ALL: begin
                wr_b0 = 1'b1;
                wr_b1 = 1'b1;
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_CELL) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (LRAM_SWAP || pend_q) begin
                    do_swap = 1'b1;
                end else if (pix.PIX_VALID) begin
                    byte_d  = pix.PIX_DATA;
                    bpal_d  = pal_q;
                    bwm_d   = wm_q;
                    bptr_d  = ptr_q;
                    rm_in_d = READ_MODE;
                    k_d     = 2'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_idx  = wr_cell_idx;
                wr_data = wr_cell;
                wr_b0   = !skip && !bank_q;
                wr_b1   = !skip && bank_q;
                k_d     = k_q + 1'b1;
                if (k_q == (bwm_q ? 2'd1 : 2'd3)) begin
                    ptr_d = bptr_q + (bwm_q ? ADDR_W'(2) : ADDR_W'(4));
                    if (pend_d) do_swap = 1'b1;
                    else        state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                wr_b0 = !bank_q;
                wr_b1 = bank_q;
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_CELL) begin
                    clr_d = '0;
                    if (pend_d) do_swap = 1'b1;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR_ALL;
        endcase
        if (do_swap) begin
            bank_d   = !bank_q;
            rm_out_d = rm_in_q;
            pend_d   = 1'b0;
            clr_d    = '0;
            state_d  = S_CLEAR;
        end
        if (INPUT_W) ptr_d = INPUT_ADDR;
    end

    // Playback: display bank is the one not being written
    logic [ADDR_W-1:0] rd_idx;
    logic [4:0]        rd_cell;
    logic [2:0]        rd_pal;
    logic [1:0]        rd_c;
    logic [4:0]        map_idx;
    always_comb begin
        rd_idx  = ADDR_W'(LRAM_OUT_COL >> 1);
        rd_cell = bank_q ? bank0[rd_idx] : bank1[rd_idx];
        case (rm_out_q)
            2'b10: begin
                rd_pal = {rd_cell[4], 2'b00};
                rd_c   = LRAM_OUT_COL[0] ? {rd_cell[0], rd_cell[2]} : {rd_cell[1], rd_cell[3]};
            end
            2'b11: begin
                rd_pal = rd_cell[4:2];
                rd_c   = LRAM_OUT_COL[0] ? {rd_cell[0], 1'b0} : {rd_cell[1], 1'b0};
            end
            default: begin
                rd_pal = rd_cell[4:2];
                rd_c   = rd_cell[1:0];
            end
        endcase
        map_idx    = {2'b00, rd_pal} * 5'd3 + {3'b000, rd_c};
        playback_d = (rd_c == 2'b00) ? COLOR_MAP[0] : COLOR_MAP[map_idx];
        if (LRAM_OUT_COL >= COL_LIMIT) playback_d = BORDER_CONTROL ? 8'h00 : COLOR_MAP[0];
        if (COLOR_KILL) playback_d[7:4] = 4'h0;
    end

    always_ff @(posedge SYSCLK) begin
        if (wr_b0) bank0[wr_idx] <= wr_data;
        if (wr_b1) bank1[wr_idx] <= wr_data;
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_CLEAR_ALL;
            ptr_q      <= '0;
            bptr_q     <= '0;
            clr_q      <= '0;
            pal_q      <= 3'd0;
            bpal_q     <= 3'd0;
            wm_q       <= 1'b0;
            bwm_q      <= 1'b0;
            rm_in_q    <= 2'd0;
            rm_out_q   <= 2'd0;
            k_q        <= 2'd0;
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            byte_q     <= 8'h00;
            playback_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            bptr_q     <= bptr_d;
            clr_q      <= clr_d;
            pal_q      <= pal_d;
            bpal_q     <= bpal_d;
            wm_q       <= wm_d;
            bwm_q      <= bwm_d;
            rm_in_q    <= rm_in_d;
            rm_out_q   <= rm_out_d;
            k_q        <= k_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            byte_q     <= byte_d;
            playback_q <= playback_d;
        end
    end

    assign PLAYBACK      = playback_q;
    assign BUSY          = (state_q != S_IDLE) || pend_q;
    assign pix.PIX_READY = (state_q == S_IDLE) && !pend_q;
endmodule

// File: tb/tb_maria_lineram_dbuf.sv
// tb/tb_maria_lineram_dbuf.sv - directed table-driven bench for maria_lineram_dbuf
module tb_maria_lineram_dbuf;
    logic       SYSCLK = 1'b0;
    logic       RESET  = 1'b1;
    logic [7:0] INPUT_ADDR = 8'd0;
    logic       INPUT_W = 1'b0;
    logic [2:0] PALETTE = 3'd0;
    logic       PALETTE_W = 1'b0;
    logic       WM = 1'b0;
    logic       WM_W = 1'b0;
    logic [1:0] READ_MODE = 2'd0;
    logic       KANGAROO_MODE = 1'b0;
    logic       BORDER_CONTROL = 1'b0;
    logic       COLOR_KILL = 1'b0;
    logic [7:0] COLOR_MAP [25];
    logic       LRAM_SWAP = 1'b0;
    logic [8:0] LRAM_OUT_COL = 9'd0;
    logic [7:0] PLAYBACK;
    logic       BUSY;

    maria_lineram_dbuf_if pix_if ();

    maria_lineram_dbuf dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .pix(pix_if),
        .INPUT_ADDR(INPUT_ADDR), .INPUT_W(INPUT_W), .PALETTE(PALETTE), .PALETTE_W(PALETTE_W),
        .WM(WM), .WM_W(WM_W), .READ_MODE(READ_MODE), .KANGAROO_MODE(KANGAROO_MODE),
        .BORDER_CONTROL(BORDER_CONTROL), .COLOR_KILL(COLOR_KILL), .COLOR_MAP(COLOR_MAP),
        .LRAM_SWAP(LRAM_SWAP), .LRAM_OUT_COL(LRAM_OUT_COL), .PLAYBACK(PLAYBACK), .BUSY(BUSY)
    );

    always #5 SYSCLK = ~SYSCLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0] col;
        logic       border;
        logic       kill;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pb(input logic [8:0] col, output logic [7:0] v);
        @(negedge SYSCLK);
        LRAM_OUT_COL = col;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        v = PLAYBACK;
    endtask

    task automatic pb_chk(input string name, input logic [8:0] col, input logic [7:0] exp);
        logic [7:0] v;
        pb(col, v);
        chk(name, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge SYSCLK);
            ok = pix_if.PIX_READY && !BUSY;
        end
        chk(tag, ok, 1);
    endtask

    task automatic set_regs(input logic [2:0] pal, input logic wm, input logic [7:0] addr);
        @(negedge SYSCLK);
        PALETTE = pal; PALETTE_W = 1'b1;
        WM = wm;       WM_W = 1'b1;
        INPUT_ADDR = addr; INPUT_W = 1'b1;
        @(negedge SYSCLK);
        PALETTE_W = 1'b0; WM_W = 1'b0; INPUT_W = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d);
        bit ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge SYSCLK);
            ok = pix_if.PIX_READY;
        end
        pix_if.PIX_DATA = d;
        pix_if.PIX_VALID = 1'b1;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        pix_if.PIX_VALID = 1'b0;
        wait_idle(tag);
    endtask

    task automatic swap(input string tag);
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b1;
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        int cyc;
        int bad;
        logic [7:0] v;
        bit busy_low;

        COLOR_MAP[0] = 8'h5A;
        for (int i = 1; i < 25; i++) COLOR_MAP[i] = 8'h80 + 8'(i);
        pix_if.PIX_DATA = 8'h00;
        pix_if.PIX_VALID = 1'b0;

        tbl[0]  = '{9'd20,  1'b0, 1'b0, 8'h8C};
        tbl[1]  = '{9'd21,  1'b0, 1'b0, 8'h8C};
        tbl[2]  = '{9'd22,  1'b0, 1'b0, 8'h5A};
        tbl[3]  = '{9'd23,  1'b0, 1'b0, 8'h5A};
        tbl[4]  = '{9'd24,  1'b0, 1'b0, 8'h8B};
        tbl[5]  = '{9'd25,  1'b0, 1'b0, 8'h8B};
        tbl[6]  = '{9'd26,  1'b0, 1'b0, 8'h8A};
        tbl[7]  = '{9'd27,  1'b0, 1'b0, 8'h8A};
        tbl[8]  = '{9'd400, 1'b0, 1'b0, 8'h5A};
        tbl[9]  = '{9'd400, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{9'd320, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{9'd319, 1'b1, 1'b0, 8'h5A};
        tbl[12] = '{9'd20,  1'b0, 1'b1, 8'h0C};
        tbl[13] = '{9'd22,  1'b0, 1'b1, 8'h0A};
        tbl[14] = '{9'd400, 1'b0, 1'b1, 8'h0A};
        tbl[15] = '{9'd400, 1'b1, 1'b1, 8'h00};

        // Reset state and CLEAR_ALL length
        repeat (3) @(negedge SYSCLK);
        chk("rst_playback", PLAYBACK, 8'h00);
        chk("rst_ready", pix_if.PIX_READY, 0);
        chk("rst_busy", BUSY, 1);
        RESET = 1'b0;
        cyc = 0;
        busy_low = 1'b0;
        while (cyc < 400) begin
            @(posedge SYSCLK);
            cyc++;
            @(negedge SYSCLK);
            if (pix_if.PIX_READY) break;
            if (!BUSY) busy_low = 1'b1;
        end
        chk("clear_all_cycles", cyc, 160);
        chk("clear_all_busy", busy_low, 0);
        chk("idle_busy", BUSY, 0);

        bad = 0;
        for (int c = 0; c < 320; c++) begin
            pb(9'(c), v);
            if (v !== 8'h5A) bad++;
        end
        chk("init_cols_bad", bad, 0);

        // WM=0 byte with a transparent field, then table of playback vectors
        set_regs(3'd3, 1'b0, 8'd10);
        READ_MODE = 2'b00;
        send_byte("t1_byte", 8'b11_00_10_01);
        swap("t1_swap");
        for (int i = 0; i < 16; i++) begin
            BORDER_CONTROL = tbl[i].border;
            COLOR_KILL = tbl[i].kill;
            pb(tbl[i].col, v);
            chk($sformatf("tbl%0d_col%0d", i, tbl[i].col), v, tbl[i].exp);
        end
        BORDER_CONTROL = 1'b0;
        COLOR_KILL = 1'b0;

        // Kangaroo mode overwrites a previously written cell with colour 0
        set_regs(3'd3, 1'b0, 8'd11);
        send_byte("kg_pre", 8'h40);
        set_regs(3'd3, 1'b0, 8'd10);
        KANGAROO_MODE = 1'b1;
        send_byte("kg_byte", 8'b11_00_10_01);
        KANGAROO_MODE = 1'b0;
        swap("kg_swap");
        pb_chk("kg_col20", 9'd20, 8'h8C);
        pb_chk("kg_col22", 9'd22, 8'h5A);
        pb_chk("kg_col23", 9'd23, 8'h5A);
        pb_chk("kg_col24", 9'd24, 8'h8B);
        pb_chk("kg_col26", 9'd26, 8'h8A);

        // WM=1, read mode 10: cell0 = 10111, cell1 transparent
        set_regs(3'd4, 1'b1, 8'd0);
        READ_MODE = 2'b10;
        send_byte("wm1_byte", 8'hC5);
        READ_MODE = 2'b00;
        swap("wm1_swap");
        pb_chk("wm1_col0", 9'd0, 8'h8E);
        pb_chk("wm1_col1", 9'd1, 8'h8F);
        pb_chk("wm1_col2", 9'd2, 8'h5A);
        pb_chk("wm1_col3", 9'd3, 8'h5A);

        // Write running off the end of the line
        set_regs(3'd2, 1'b0, 8'd158);
        send_byte("edge_byte", 8'hFF);
        swap("edge_swap");
        pb_chk("edge_col316", 9'd316, 8'h89);
        pb_chk("edge_col319", 9'd319, 8'h89);
        pb_chk("edge_col314", 9'd314, 8'h5A);
        pb_chk("edge_col0", 9'd0, 8'h5A);

        // Two swap pulses during WRITE merge into one swap + one CLEAR
        set_regs(3'd1, 1'b0, 8'd40);
        cyc = 0;
        while (!pix_if.PIX_READY && cyc < 500) begin
            @(negedge SYSCLK);
            cyc++;
        end
        pix_if.PIX_DATA = 8'hE4;
        pix_if.PIX_VALID = 1'b1;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        pix_if.PIX_VALID = 1'b0;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b1;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b0;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b1;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        LRAM_SWAP = 1'b0;
        chk("mg_busy", BUSY, 1);
        chk("mg_ready", pix_if.PIX_READY, 0);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge SYSCLK);
            cyc++;
            @(negedge SYSCLK);
            if (pix_if.PIX_READY) break;
        end
        chk("mg_clear_cycles", cyc, 160);
        chk("mg_busy_after", BUSY, 0);
        pb_chk("mg_col80", 9'd80, 8'h86);
        pb_chk("mg_col82", 9'd82, 8'h85);
        pb_chk("mg_col84", 9'd84, 8'h84);
        pb_chk("mg_col86", 9'd86, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
